// File: rtl/uart_pkg.sv
// Shared UART framing definitions: default timing parameters and receiver FSM state encoding.
package uart_pkg;

    localparam int UART_CLK_DIV    = 27;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef logic [2:0] uart_rx_state_t;

    localparam uart_rx_state_t ST_IDLE  = 3'd0;
    localparam uart_rx_state_t ST_START = 3'd1;
    localparam uart_rx_state_t ST_DATA  = 3'd2;
    localparam uart_rx_state_t ST_STOP  = 3'd3;
    localparam uart_rx_state_t ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every CLK_DIV clocks, phase restartable by clear.
module uart_baud_tick #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_top.sv
// 8N1 UART receiver: synchronises rx_in, finds mid-bit sample points with an oversample tick,
// and presents each good byte with a one-cycle strobe or flags a bad stop bit.
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = UART_CLK_DIV,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    uart_rx_state_t state_reg, state_next;

    logic                 sync1, rxs, rxs_d;
    logic                 tick, falling, at_mid, at_full;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 start_det, sample_en, valid_next, ferr_next;

    // Synchroniser and edge history reset high so an idle line never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rxs   <= sync1;
            rxs_d <= rxs;
        end
    end

    assign falling = rxs_d & ~rxs;
    assign at_mid  = tick && (tick_cnt == TICK_HALF);
    assign at_full = tick && (tick_cnt == TICK_LAST);

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (start_det),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (falling) state_next = ST_START;
            ST_START: if (at_mid) state_next = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:  if (at_full && bit_cnt == BIT_LAST) state_next = ST_STOP;
            ST_STOP:  if (at_full) state_next = rxs ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rxs) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_reg != ST_IDLE);
        start_det  = (state_reg == ST_IDLE) && falling;
        sample_en  = (state_reg == ST_DATA) && at_full;
        valid_next = (state_reg == ST_STOP) && at_full && rxs;
        ferr_next  = (state_reg == ST_STOP) && at_full && !rxs;
    end

    // Start-bit checkpoint restarts the tick count so later samples land a full bit apart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (start_det) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state_reg == ST_START && at_mid) begin
            tick_cnt <= '0;
        end else if ((state_reg == ST_START || state_reg == ST_DATA ||
                      state_reg == ST_STOP) && tick) begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            if (sample_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (sample_en) begin
                shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
            end
            if (valid_next) begin
                rx_data <= shift_reg;
            end
            rx_valid  <= valid_next;
            frame_err <= ferr_next;
        end
    end

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed bench for uart_rx_top: 16 clk/bit instance for framing cases, CLK_DIV=27 instance
// for the full-rate frame case.
module tb_uart_rx_top;

    logic       clk;
    logic       reset;
    logic       rx_a, rx_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, ferr_a, ferr_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;
    int valid_cnt_a = 0, ferr_cnt_a = 0, valid_cnt_b = 0, ferr_cnt_b = 0, overlap_cnt = 0;
    logic [7:0] log_a [0:31];

    uart_rx_top #(.CLK_DIV(1), .OVERSAMPLE(16), .DATA_BITS(8)) dut_a (
        .clk(clk), .reset(reset), .rx_in(rx_a),
        .rx_data(data_a), .rx_valid(valid_a), .frame_err(ferr_a), .busy(busy_a)
    );

    uart_rx_top #(.CLK_DIV(27), .OVERSAMPLE(16), .DATA_BITS(8)) dut_b (
        .clk(clk), .reset(reset), .rx_in(rx_b),
        .rx_data(data_b), .rx_valid(valid_b), .frame_err(ferr_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_a) begin
            if (valid_cnt_a < 32) log_a[valid_cnt_a] = data_a;
            valid_cnt_a++;
        end
        if (ferr_a) ferr_cnt_a++;
        if (valid_b) valid_cnt_b++;
        if (ferr_b) ferr_cnt_b++;
        if ((valid_a && ferr_a) || (valid_b && ferr_b)) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic bit_out(input logic sel, input logic v, input int n);
        if (sel) rx_b = v; else rx_a = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic sel, input logic [7:0] d, input logic stop_val,
                              input int bitc, input int stopc);
        bit_out(sel, 1'b0, bitc);
        for (int i = 0; i < 8; i++) bit_out(sel, d[i], bitc);
        bit_out(sel, stop_val, stopc);
    endtask

    int v0, f0;

    initial begin
        reset = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_data", {24'd0, data_a}, 32'h00);
        check("reset_rx_valid", {31'd0, valid_a}, 32'd0);
        check("reset_frame_err", {31'd0, ferr_a}, 32'd0);
        check("reset_busy", {31'd0, busy_a}, 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Single good frame
        v0 = valid_cnt_a; f0 = ferr_cnt_a;
        send_frame(1'b0, 8'hAA, 1'b1, 16, 16);
        repeat (20) @(negedge clk);
        check("aa_valid_pulses", valid_cnt_a - v0, 1);
        check("aa_rx_data", {24'd0, data_a}, 32'hAA);
        check("aa_frame_err", ferr_cnt_a - f0, 0);

        // Back-to-back frames, no idle gap
        v0 = valid_cnt_a;
        send_frame(1'b0, 8'h00, 1'b1, 16, 16);
        send_frame(1'b0, 8'hFF, 1'b1, 16, 16);
        repeat (20) @(negedge clk);
        check("b2b_valid_pulses", valid_cnt_a - v0, 2);
        check("b2b_first_data", {24'd0, log_a[v0 % 32]}, 32'h00);
        check("b2b_second_data", {24'd0, log_a[(v0 + 1) % 32]}, 32'hFF);

        // Short low glitch on idle line
        v0 = valid_cnt_a;
        bit_out(1'b0, 1'b0, 4);
        bit_out(1'b0, 1'b1, 4);
        check("glitch_busy_seen", {31'd0, busy_a}, 32'd1);
        repeat (6) @(negedge clk);
        check("glitch_busy_cleared", {31'd0, busy_a}, 32'd0);
        check("glitch_no_valid", valid_cnt_a - v0, 0);
        check("glitch_rx_data", {24'd0, data_a}, 32'hFF);

        // Bad stop bit, line held low, then recovery
        v0 = valid_cnt_a; f0 = ferr_cnt_a;
        send_frame(1'b0, 8'h55, 1'b0, 16, 40);
        check("break_busy_held", {31'd0, busy_a}, 32'd1);
        bit_out(1'b0, 1'b1, 20);
        check("ferr_pulses", ferr_cnt_a - f0, 1);
        check("ferr_no_valid", valid_cnt_a - v0, 0);
        check("ferr_rx_data_kept", {24'd0, data_a}, 32'hFF);
        send_frame(1'b0, 8'h3C, 1'b1, 16, 16);
        repeat (20) @(negedge clk);
        check("after_break_rx_data", {24'd0, data_a}, 32'h3C);
        check("after_break_valid", valid_cnt_a - v0, 1);

        // Reset mid-data-bit of 0xC3 (bits LSB first: 1,1,0,0,...)
        bit_out(1'b0, 1'b0, 16);
        bit_out(1'b0, 1'b1, 16);
        bit_out(1'b0, 1'b1, 16);
        bit_out(1'b0, 1'b0, 8);
        check("midframe_busy", {31'd0, busy_a}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_rx_data", {24'd0, data_a}, 32'h00);
        check("abort_busy", {31'd0, busy_a}, 32'd0);
        check("abort_rx_valid", {31'd0, valid_a}, 32'd0);
        check("abort_frame_err", {31'd0, ferr_a}, 32'd0);
        @(negedge clk);
        rx_a = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        v0 = valid_cnt_a;
        send_frame(1'b0, 8'h3C, 1'b1, 16, 16);
        repeat (20) @(negedge clk);
        check("post_reset_rx_data", {24'd0, data_a}, 32'h3C);
        check("post_reset_valid", valid_cnt_a - v0, 1);

        // Full-rate divider: two 0xAA frames at 432 clk/bit
        send_frame(1'b1, 8'hAA, 1'b1, 432, 432);
        send_frame(1'b1, 8'hAA, 1'b1, 432, 432);
        repeat (50) @(negedge clk);
        check("div27_valid_pulses", valid_cnt_b, 2);
        check("div27_rx_data", {24'd0, data_b}, 32'hAA);
        check("div27_frame_err", ferr_cnt_b, 0);
        check("valid_ferr_overlap", overlap_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
